// File: rtl/mem_port_pkg.sv
// Shared definitions for the two-requester memory port arbiter.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of
// fixed priority (m0 > m1) with an m1 starvation guard.
package mem_port_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned SIZE_W   = 2;
    localparam int unsigned STARVE_W = 8;

    // Requester index; also the encoding stored in last_grant / rsp_owner.
    typedef enum logic {
        REQ_M0 = 1'b0,
        REQ_M1 = 1'b1
    } req_idx_t;

    // Command payload carried from a requester to the shared port.
    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] data;
        logic [SIZE_W-1:0] size;
    } mem_cmd_t;

endpackage

// File: rtl/arb_grant.sv
// Grant decision for the memory port arbiter: combinational grant from the
// request valids plus registered last_grant, stall-hold and starvation state.
// Build option: ARB_ROUND_ROBIN_EN (round-robin, no starvation counter).
module arb_grant
    import mem_port_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     m0_valid_i,
    input  logic     m1_valid_i,
    input  logic     s_ready_i,
    output logic     gnt_valid_c,
    output req_idx_t gnt_idx_c
);

    req_idx_t last_grant_q, last_grant_d;
    req_idx_t hold_idx_q, hold_idx_d;
    logic     hold_q, hold_d;
    logic     held_valid;
    logic     accept;
    logic     both_pick_m1;

    // A stalled command keeps its grant only while its requester still asserts valid.
    assign held_valid = (hold_idx_q == REQ_M1) ? m1_valid_i : m0_valid_i;
    assign accept     = gnt_valid_c && s_ready_i;

`ifdef ARB_ROUND_ROBIN_EN
    // Contention goes to whichever requester did not win last.
    assign both_pick_m1 = (last_grant_q == REQ_M0);
`else
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

    // Contention goes to m0 unless m1 has waited STARVE_LIMIT cycles.
    assign both_pick_m1 = (starve_cnt_q >= STARVE_W'(STARVE_LIMIT));

    // Count m1 waiting cycles; clear when m1 is served or withdraws; saturate.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!m1_valid_i || (accept && (gnt_idx_c == REQ_M1))) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != {STARVE_W{1'b1}}) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    // Grant selection: stall hold first, then contention policy, then lone requester.
    always_comb begin
        gnt_valid_c = 1'b0;
        gnt_idx_c   = REQ_M0;
        if (hold_q && held_valid) begin
            gnt_valid_c = 1'b1;
            gnt_idx_c   = hold_idx_q;
        end else if (m0_valid_i && m1_valid_i) begin
            gnt_valid_c = 1'b1;
            gnt_idx_c   = both_pick_m1 ? REQ_M1 : REQ_M0;
        end else if (m0_valid_i) begin
            gnt_valid_c = 1'b1;
            gnt_idx_c   = REQ_M0;
        end else if (m1_valid_i) begin
            gnt_valid_c = 1'b1;
            gnt_idx_c   = REQ_M1;
        end
    end

    // Next state: remember winner on accept, hold grant across a stall.
    always_comb begin
        last_grant_d = last_grant_q;
        hold_d       = 1'b0;
        hold_idx_d   = hold_idx_q;
        if (accept) begin
            last_grant_d = gnt_idx_c;
        end
        if (gnt_valid_c && !s_ready_i) begin
            hold_d     = 1'b1;
            hold_idx_d = gnt_idx_c;
        end
    end

    // Arbitration state; last_grant resets to m1 so m0 wins the first contention.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= REQ_M1;
            hold_q       <= 1'b0;
            hold_idx_q   <= REQ_M0;
        end else begin
            last_grant_q <= last_grant_d;
            hold_q       <= hold_d;
            hold_idx_q   <= hold_idx_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter onto one shared memory/peripheral port. Commands pass
// through combinationally; read responses (one cycle after accept) are routed
// back to the requester that issued the read.
// Build option: ARB_ROUND_ROBIN_EN (round-robin instead of fixed priority).
module mem_port_arbiter
    import mem_port_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              m0_cmd_valid,
    output logic              m0_cmd_ready,
    input  logic              m0_cmd_wr,
    input  logic [ADDR_W-1:0] m0_cmd_address,
    input  logic [DATA_W-1:0] m0_cmd_data,
    input  logic [SIZE_W-1:0] m0_cmd_size,
    output logic              m0_rsp_valid,
    output logic [DATA_W-1:0] m0_rsp_data,

    input  logic              m1_cmd_valid,
    output logic              m1_cmd_ready,
    input  logic              m1_cmd_wr,
    input  logic [ADDR_W-1:0] m1_cmd_address,
    input  logic [DATA_W-1:0] m1_cmd_data,
    input  logic [SIZE_W-1:0] m1_cmd_size,
    output logic              m1_rsp_valid,
    output logic [DATA_W-1:0] m1_rsp_data,

    output logic              s_cmd_valid,
    input  logic              s_cmd_ready,
    output logic              s_cmd_wr,
    output logic [ADDR_W-1:0] s_cmd_address,
    output logic [DATA_W-1:0] s_cmd_data,
    output logic [SIZE_W-1:0] s_cmd_size,
    input  logic              s_rsp_valid,
    input  logic [DATA_W-1:0] s_rsp_data
);

    mem_cmd_t m0_cmd, m1_cmd, sel_cmd;
    logic     gnt_valid;
    req_idx_t gnt_idx;
    logic     rd_accept;
    logic     rsp_pending_q, rsp_pending_d;
    req_idx_t rsp_owner_q, rsp_owner_d;

    assign m0_cmd = {m0_cmd_wr, m0_cmd_address, m0_cmd_data, m0_cmd_size};
    assign m1_cmd = {m1_cmd_wr, m1_cmd_address, m1_cmd_data, m1_cmd_size};

    arb_grant #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_arb_grant (
        .clk         (clk),
        .reset_n     (reset_n),
        .m0_valid_i  (m0_cmd_valid),
        .m1_valid_i  (m1_cmd_valid),
        .s_ready_i   (s_cmd_ready),
        .gnt_valid_c (gnt_valid),
        .gnt_idx_c   (gnt_idx)
    );

    // Command mux and ready fan-back; everything is forced quiet while in reset.
    always_comb begin
        sel_cmd       = (gnt_idx == REQ_M1) ? m1_cmd : m0_cmd;
        s_cmd_valid   = 1'b0;
        s_cmd_wr      = 1'b0;
        s_cmd_address = '0;
        s_cmd_data    = '0;
        s_cmd_size    = '0;
        m0_cmd_ready  = 1'b0;
        m1_cmd_ready  = 1'b0;
        if (reset_n && gnt_valid) begin
            s_cmd_valid   = 1'b1;
            s_cmd_wr      = sel_cmd.wr;
            s_cmd_address = sel_cmd.address;
            s_cmd_data    = sel_cmd.data;
            s_cmd_size    = sel_cmd.size;
            m0_cmd_ready  = (gnt_idx == REQ_M0) && s_cmd_ready;
            m1_cmd_ready  = (gnt_idx == REQ_M1) && s_cmd_ready;
        end
    end

    assign rd_accept = s_cmd_valid && s_cmd_ready && !s_cmd_wr;

    // Response routing: only a response we are expecting reaches its owner.
    always_comb begin
        m0_rsp_valid = 1'b0;
        m0_rsp_data  = '0;
        m1_rsp_valid = 1'b0;
        m1_rsp_data  = '0;
        if (reset_n && rsp_pending_q && s_rsp_valid) begin
            if (rsp_owner_q == REQ_M1) begin
                m1_rsp_valid = 1'b1;
                m1_rsp_data  = s_rsp_data;
            end else begin
                m0_rsp_valid = 1'b1;
                m0_rsp_data  = s_rsp_data;
            end
        end
    end

    // Response tracking next state: pending for exactly one cycle after a read.
    always_comb begin
        rsp_pending_d = rd_accept;
        rsp_owner_d   = rd_accept ? gnt_idx : rsp_owner_q;
    end

    // Response tracking registers; reset drops any in-flight read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_pending_q <= 1'b0;
            rsp_owner_q   <= REQ_M0;
        end else begin
            rsp_pending_q <= rsp_pending_d;
            rsp_owner_q   <= rsp_owner_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (STARVE_LIMIT=3). Expected accepted
// commands and responses are queued by the stimulus; a negedge monitor pops
// and compares whenever the port accepts a command or a response is delivered.
// Honors ARB_ROUND_ROBIN_EN for the contention grant order.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_cmd_valid, m0_cmd_ready, m0_cmd_wr;
    logic [31:0] m0_cmd_address, m0_cmd_data;
    logic [1:0]  m0_cmd_size;
    logic        m0_rsp_valid;
    logic [31:0] m0_rsp_data;
    logic        m1_cmd_valid, m1_cmd_ready, m1_cmd_wr;
    logic [31:0] m1_cmd_address, m1_cmd_data;
    logic [1:0]  m1_cmd_size;
    logic        m1_rsp_valid;
    logic [31:0] m1_rsp_data;
    logic        s_cmd_valid, s_cmd_ready, s_cmd_wr;
    logic [31:0] s_cmd_address, s_cmd_data;
    logic [1:0]  s_cmd_size;
    logic        s_rsp_valid;
    logic [31:0] s_rsp_data;

    int total = 0;
    int bad   = 0;

    logic [66:0] exp_cmd_q[$];
    logic [65:0] exp_rsp_q[$];

    logic        rd_seen = 1'b0;
    logic [31:0] rd_addr = 32'h0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m0_cmd_valid   (m0_cmd_valid),
        .m0_cmd_ready   (m0_cmd_ready),
        .m0_cmd_wr      (m0_cmd_wr),
        .m0_cmd_address (m0_cmd_address),
        .m0_cmd_data    (m0_cmd_data),
        .m0_cmd_size    (m0_cmd_size),
        .m0_rsp_valid   (m0_rsp_valid),
        .m0_rsp_data    (m0_rsp_data),
        .m1_cmd_valid   (m1_cmd_valid),
        .m1_cmd_ready   (m1_cmd_ready),
        .m1_cmd_wr      (m1_cmd_wr),
        .m1_cmd_address (m1_cmd_address),
        .m1_cmd_data    (m1_cmd_data),
        .m1_cmd_size    (m1_cmd_size),
        .m1_rsp_valid   (m1_rsp_valid),
        .m1_rsp_data    (m1_rsp_data),
        .s_cmd_valid    (s_cmd_valid),
        .s_cmd_ready    (s_cmd_ready),
        .s_cmd_wr       (s_cmd_wr),
        .s_cmd_address  (s_cmd_address),
        .s_cmd_data     (s_cmd_data),
        .s_cmd_size     (s_cmd_size),
        .s_rsp_valid    (s_rsp_valid),
        .s_rsp_data     (s_rsp_data)
    );

    task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [66:0] cmd_vec(input logic [1:0] own, input logic wr,
                                            input logic [31:0] a, input logic [31:0] d);
        return {own, wr, a, d};
    endfunction

    function automatic logic [65:0] rsp_vec(input logic own, input logic [31:0] d);
        return own ? {2'b10, 32'h0, d} : {2'b01, d, 32'h0};
    endfunction

    // Slave read data model used to drive s_rsp_data.
    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : (a ^ 32'hFFFF_0000);
    endfunction

    // Monitor: compare every accepted command and every delivered response.
    always @(negedge clk) begin
        logic [1:0]  own;
        logic [66:0] act_c;
        logic [65:0] act_r;
        if (s_cmd_valid && s_cmd_ready) begin
            own   = (m0_cmd_ready && !m1_cmd_ready) ? 2'd0 :
                    (m1_cmd_ready && !m0_cmd_ready) ? 2'd1 : 2'd3;
            act_c = {own, s_cmd_wr, s_cmd_address, s_cmd_data};
            if (exp_cmd_q.size() == 0) begin
                check("cmd_unexpected", 96'(act_c), 96'h0);
            end else begin
                check("cmd_accept", 96'(act_c), 96'(exp_cmd_q.pop_front()));
            end
            rd_seen = !s_cmd_wr;
            rd_addr = s_cmd_address;
        end else begin
            rd_seen = 1'b0;
        end
        if (m0_rsp_valid || m1_rsp_valid) begin
            act_r = {m1_rsp_valid, m0_rsp_valid, m0_rsp_data, m1_rsp_data};
            if (exp_rsp_q.size() == 0) begin
                check("rsp_unexpected", 96'(act_r), 96'h0);
            end else begin
                check("rsp_route", 96'(act_r), 96'(exp_rsp_q.pop_front()));
            end
        end
    end

    // Advance one clock; the slave answers the read accepted in the previous cycle.
    task automatic cycle();
        @(posedge clk);
        #1;
        s_rsp_valid = rd_seen;
        s_rsp_data  = rd_seen ? slave_data(rd_addr) : 32'h0;
    endtask

    task automatic set_m0(input logic v, input logic wr, input logic [31:0] a, input logic [31:0] d);
        m0_cmd_valid = v; m0_cmd_wr = wr; m0_cmd_address = a; m0_cmd_data = d; m0_cmd_size = 2'd2;
    endtask

    task automatic set_m1(input logic v, input logic wr, input logic [31:0] a, input logic [31:0] d);
        m1_cmd_valid = v; m1_cmd_wr = wr; m1_cmd_address = a; m1_cmd_data = d; m1_cmd_size = 2'd2;
    endtask

    initial begin
        logic [8:0] seq;

        // Reset with every input active: outputs must stay quiet.
        reset_n = 1'b0;
        set_m0(1'b1, 1'b0, 32'h55, 32'h1);
        set_m1(1'b1, 1'b0, 32'h66, 32'h2);
        s_cmd_ready = 1'b1;
        s_rsp_valid = 1'b1;
        s_rsp_data  = 32'hFFFF_FFFF;
        #12;
        check("rst_s_cmd_valid", 96'(s_cmd_valid), 96'h0);
        check("rst_cmd_ready", 96'({m0_cmd_ready, m1_cmd_ready}), 96'h0);
        check("rst_rsp_valid", 96'({m0_rsp_valid, m1_rsp_valid}), 96'h0);
        check("rst_data_out", 96'({s_cmd_address, m0_rsp_data, m1_rsp_data}), 96'h0);

        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0);
        s_rsp_valid = 1'b0;
        cycle();
        reset_n = 1'b1;
        cycle();
        #1 check("idle_s_cmd_valid", 96'(s_cmd_valid), 96'h0);

        // m0 reads 0x10, response next cycle to m0 only.
        cycle();
        set_m0(1'b1, 1'b0, 32'h10, 32'h0);
        exp_cmd_q.push_back(cmd_vec(2'd0, 1'b0, 32'h10, 32'h0));
        exp_rsp_q.push_back(rsp_vec(1'b0, 32'hDEAD_BEEF));
        cycle();
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        #1 check("m0_rd_rsp_now", 96'(m0_rsp_valid), 96'h1);
        cycle();
        cycle();

        // m0 write then back-to-back m1 read: only the read answers.
        set_m0(1'b1, 1'b1, 32'h20, 32'h1111_2222);
        exp_cmd_q.push_back(cmd_vec(2'd0, 1'b1, 32'h20, 32'h1111_2222));
        cycle();
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        set_m1(1'b1, 1'b0, 32'h30, 32'h0);
        exp_cmd_q.push_back(cmd_vec(2'd1, 1'b0, 32'h30, 32'h0));
        exp_rsp_q.push_back(rsp_vec(1'b1, 32'hFFFF_0030));
        #1 check("no_rsp_for_write", 96'({m0_rsp_valid, m1_rsp_valid}), 96'h0);
        cycle();
        set_m1(1'b0, 1'b0, 32'h0, 32'h0);
        cycle();
        cycle();

        // Continuous contention for nine accepted transfers.
`ifdef ARB_ROUND_ROBIN_EN
        seq = 9'h0AA;
`else
        seq = 9'h088;
`endif
        set_m0(1'b1, 1'b1, 32'h100, 32'hAAAA_0000);
        set_m1(1'b1, 1'b1, 32'h200, 32'hBBBB_0000);
        for (int i = 0; i < 9; i++) begin
            if (seq[i]) exp_cmd_q.push_back(cmd_vec(2'd1, 1'b1, 32'h200, 32'hBBBB_0000));
            else        exp_cmd_q.push_back(cmd_vec(2'd0, 1'b1, 32'h100, 32'hAAAA_0000));
        end
        repeat (9) cycle();
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0);
        cycle();

        // m1 write stalled three cycles while m0 arrives: grant stays on m1.
        s_cmd_ready = 1'b0;
        set_m1(1'b1, 1'b1, 32'h300, 32'hCCCC_0003);
        #1 check("stall_gnt_c0", 96'(s_cmd_address), 96'h300);
        cycle();
        set_m0(1'b1, 1'b1, 32'h400, 32'hDDDD_0004);
        #1 check("stall_gnt_c1", 96'({s_cmd_address, m0_cmd_ready, m1_cmd_ready}), 96'({32'h300, 2'b00}));
        cycle();
        #1 check("stall_gnt_c2", 96'({s_cmd_address, m0_cmd_ready, m1_cmd_ready}), 96'({32'h300, 2'b00}));
        cycle();
        s_cmd_ready = 1'b1;
        exp_cmd_q.push_back(cmd_vec(2'd1, 1'b1, 32'h300, 32'hCCCC_0003));
        exp_cmd_q.push_back(cmd_vec(2'd0, 1'b1, 32'h400, 32'hDDDD_0004));
        #1 check("stall_release", 96'({m0_cmd_ready, m1_cmd_ready}), 96'(2'b01));
        cycle();
        set_m1(1'b0, 1'b0, 32'h0, 32'h0);
        cycle();
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        cycle();

        // m1 read accepted, then reset while the slave answers: response dropped.
        set_m1(1'b1, 1'b0, 32'h40, 32'h0);
        exp_cmd_q.push_back(cmd_vec(2'd1, 1'b0, 32'h40, 32'h0));
        cycle();
        set_m1(1'b0, 1'b0, 32'h0, 32'h0);
        reset_n = 1'b0;
        #1 check("rst_mid_rsp", 96'({m0_rsp_valid, m1_rsp_valid, s_cmd_valid}), 96'h0);
        cycle();
        s_rsp_valid = 1'b1;
        s_rsp_data  = 32'h0BAD_0BAD;
        cycle();
        reset_n = 1'b1;
        s_rsp_valid = 1'b1;
        s_rsp_data  = 32'h0BAD_0BAD;
        #1 check("stray_rsp_ignored", 96'({m0_rsp_valid, m1_rsp_valid}), 96'h0);
        cycle();

        // First post-reset contention goes to m0; its read gets the response.
        set_m0(1'b1, 1'b0, 32'h10, 32'h0);
        set_m1(1'b1, 1'b1, 32'h500, 32'hEEEE_0005);
        exp_cmd_q.push_back(cmd_vec(2'd0, 1'b0, 32'h10, 32'h0));
        exp_cmd_q.push_back(cmd_vec(2'd1, 1'b1, 32'h500, 32'hEEEE_0005));
        exp_rsp_q.push_back(rsp_vec(1'b0, 32'hDEAD_BEEF));
        cycle();
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        cycle();
        set_m1(1'b0, 1'b0, 32'h0, 32'h0);
        cycle();
        cycle();

        check("cmd_q_drained", 96'(exp_cmd_q.size()), 96'h0);
        check("rsp_q_drained", 96'(exp_rsp_q.size()), 96'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
